// File: rtl/hamming_uart_tx.sv
// hamming_uart_tx
// Encodes an 11-bit payload as Hamming(15,11) and serialises it at one bit
// per clock. Frame: start(0), code[14]..code[0], stop(1), then IDLE_GAP idle
// cycles. The line idles high. An optional single-bit injector flips one
// codeword position.
//
// Ports:
//   clk_tx        in   clock, rising edge
//   rst_tx        in   asynchronous active-high reset
//   data_in_tx    in   payload d[10:0]
//   err_pos_tx    in   0 = clean, 1..15 = flip code[err_pos_tx-1]
//   valid_in_tx   in   payload/err_pos valid
//   ready_tx      out  high only in IDLE (combinational from state)
//   msg_out_tx    out  serial line (flop driven)
//   busy_tx       out  high while a frame or its gap is in progress
//   frame_done_tx out  one-cycle pulse while the stop bit is on the line
module hamming_uart_tx #(
    parameter int unsigned IDLE_GAP   = 1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic        clk_tx,
    input  logic        rst_tx,
    input  logic [10:0] data_in_tx,
    input  logic [3:0]  err_pos_tx,
    input  logic        valid_in_tx,
    output logic        ready_tx,
    output logic        msg_out_tx,
    output logic        busy_tx,
    output logic        frame_done_tx
);

    localparam int unsigned CODE_W = 15;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t              state_q;
    logic [CODE_W-1:0]   shreg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                line_q;
    logic                done_q;

    logic [CODE_W-1:0]   raw_c;
    logic [CODE_W-1:0]   flip_c;
    logic [CODE_W-1:0]   code_c;
    logic                accept_c;

    // Hamming(15,11) encoder; position n lives at raw_c[n-1]
    always_comb begin
        raw_c      = '0;
        raw_c[2]   = data_in_tx[0];
        raw_c[4]   = data_in_tx[1];
        raw_c[5]   = data_in_tx[2];
        raw_c[6]   = data_in_tx[3];
        raw_c[8]   = data_in_tx[4];
        raw_c[9]   = data_in_tx[5];
        raw_c[10]  = data_in_tx[6];
        raw_c[11]  = data_in_tx[7];
        raw_c[12]  = data_in_tx[8];
        raw_c[13]  = data_in_tx[9];
        raw_c[14]  = data_in_tx[10];
        raw_c[0]   = PARITY_ODD ^ raw_c[2] ^ raw_c[4] ^ raw_c[6] ^ raw_c[8]
                                ^ raw_c[10] ^ raw_c[12] ^ raw_c[14];
        raw_c[1]   = PARITY_ODD ^ raw_c[2] ^ raw_c[5] ^ raw_c[6] ^ raw_c[9]
                                ^ raw_c[10] ^ raw_c[13] ^ raw_c[14];
        raw_c[3]   = PARITY_ODD ^ raw_c[4] ^ raw_c[5] ^ raw_c[6] ^ raw_c[11]
                                ^ raw_c[12] ^ raw_c[13] ^ raw_c[14];
        raw_c[7]   = PARITY_ODD ^ raw_c[8] ^ raw_c[9] ^ raw_c[10] ^ raw_c[11]
                                ^ raw_c[12] ^ raw_c[13] ^ raw_c[14];
    end

    // Error injector: position 0 means no flip
    always_comb begin
        flip_c = '0;
        if (err_pos_tx != 4'd0) begin
            flip_c = CODE_W'(1) << (err_pos_tx - 4'd1);
        end
        code_c = raw_c ^ flip_c;
    end

    assign accept_c = valid_in_tx & ready_tx;

    // Frame sequencer; line_q always holds the bit of the state being entered
    always_ff @(posedge clk_tx or posedge rst_tx) begin
        if (rst_tx) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    line_q <= 1'b1;
                    if (accept_c) begin
                        shreg_q <= code_c;
                        line_q  <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    line_q  <= shreg_q[CODE_W-1];
                    shreg_q <= {shreg_q[CODE_W-2:0], 1'b0};
                    cnt_q   <= '0;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (cnt_q == LAST_DATA) begin
                        line_q  <= 1'b1;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                    end else begin
                        line_q  <= shreg_q[CODE_W-1];
                        shreg_q <= {shreg_q[CODE_W-2:0], 1'b0};
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    line_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    line_q <= 1'b1;
                    if (cnt_q == LAST_GAP) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    line_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_tx      = (state_q == S_IDLE);
    assign busy_tx       = (state_q != S_IDLE);
    assign msg_out_tx    = line_q;
    assign frame_done_tx = done_q;

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Bench for hamming_uart_tx: two instances (even parity/gap 1, odd parity/gap 3)
// driven with directed and random frames, each compared to a reference encoder.
module tb_hamming_uart_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic [10:0] din  [2];
    logic [3:0]  epos [2];
    logic        vld  [2];
    logic        rdy  [2];
    logic        line [2];
    logic        busy [2];
    logic        done [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    hamming_uart_tx #(.IDLE_GAP(1), .PARITY_ODD(1'b0)) u_even (
        .clk_tx(clk), .rst_tx(rst[0]), .data_in_tx(din[0]), .err_pos_tx(epos[0]),
        .valid_in_tx(vld[0]), .ready_tx(rdy[0]), .msg_out_tx(line[0]),
        .busy_tx(busy[0]), .frame_done_tx(done[0])
    );

    hamming_uart_tx #(.IDLE_GAP(3), .PARITY_ODD(1'b1)) u_odd (
        .clk_tx(clk), .rst_tx(rst[1]), .data_in_tx(din[1]), .err_pos_tx(epos[1]),
        .valid_in_tx(vld[1]), .ready_tx(rdy[1]), .msg_out_tx(line[1]),
        .busy_tx(busy[1]), .frame_done_tx(done[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int gap_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Reference encoder: non-power-of-two positions take data in order,
    // parity bit p covers every position whose index has bit p set.
    function automatic logic [14:0] ref_code(input logic [10:0] d, input bit odd, input logic [3:0] e);
        logic [14:0] c;
        int k;
        bit par;
        c = '0;
        k = 0;
        for (int n = 1; n <= 15; n++) begin
            if ((n & (n - 1)) != 0) begin
                c[n-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = odd;
            for (int n = 1; n <= 15; n++)
                if ((n & p) != 0 && n != p) par ^= c[n-1];
            c[p-1] = par;
        end
        if (e != 4'd0) c[e-1] = ~c[e-1];
        return c;
    endfunction

    // Sends one frame and checks every line cycle; leaves valid high when keep=1
    task automatic run_frame(input int u, input logic [10:0] d, input logic [3:0] e,
                             input bit keep, output int acc_cyc);
        logic [14:0] exp, got;
        int w;
        bit bad_busy, bad_done, bad_gap;
        exp = ref_code(d, u == 1, e);
        din[u] = d; epos[u] = e; vld[u] = 1'b1;
        w = 0;
        while (!rdy[u] && w < 100) begin @(posedge clk); #1; w++; end
        check_val("ready_before_accept", rdy[u], 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!keep) begin
            vld[u] = 1'b0;
            din[u] = 11'($urandom);
            epos[u] = 4'($urandom);
        end
        check_val("start_bit", line[u], 0);
        check_val("ready_low_in_frame", rdy[u], 0);
        bad_busy = 0; bad_done = 0; bad_gap = 0;
        got = '0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            got[14-i] = line[u];
            if (!busy[u] || rdy[u]) bad_busy = 1;
            if (done[u]) bad_done = 1;
        end
        check_val("codeword", got, exp);
        check_val("busy_in_data", bad_busy, 0);
        check_val("no_early_done", bad_done, 0);
        @(posedge clk); #1;
        check_val("stop_bit", line[u], 1);
        check_val("done_pulse", done[u], 1);
        w = 0;
        while (!rdy[u] && w < 50) begin
            @(posedge clk); #1;
            w++;
            if (!line[u] && !rdy[u]) bad_gap = 1;
            if (done[u]) bad_gap = 1;
        end
        check_val("ready_return", w, gap_of(u) + 1);
        check_val("gap_line_high", bad_gap, 0);
    endtask

    initial begin
        int c1, c2;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; din[u] = '0; epos[u] = '0; vld[u] = 1'b0;
        end
        #12;
        for (int u = 0; u < 2; u++) begin
            check_val("rst_line", line[u], 1);
            check_val("rst_ready", rdy[u], 1);
            check_val("rst_busy", busy[u], 0);
            check_val("rst_done", done[u], 0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;

        // directed frames
        run_frame(0, 11'h000, 4'd0, 0, c1);
        run_frame(0, 11'h7FF, 4'd0, 0, c1);
        run_frame(0, 11'h001, 4'd0, 0, c1);
        run_frame(0, 11'h001, 4'd4, 0, c1);
        run_frame(0, 11'h555, 4'd15, 0, c1);
        run_frame(0, 11'h2AA, 4'd1, 0, c1);
        run_frame(1, 11'h000, 4'd0, 0, c1);
        run_frame(1, 11'h7FF, 4'd8, 0, c1);

        // back-to-back with valid held high
        run_frame(0, 11'h123, 4'd0, 1, c1);
        run_frame(0, 11'h456, 4'd0, 0, c2);
        check_val("b2b_spacing_even", c2 - c1, 19);
        run_frame(1, 11'h3C3, 4'd0, 1, c1);
        run_frame(1, 11'h0F0, 4'd7, 0, c2);
        check_val("b2b_spacing_odd", c2 - c1, 21);

        // reset mid-frame with an all-zero codeword so the line is low at k+8
        din[0] = 11'h000; epos[0] = 4'd0; vld[0] = 1'b1;
        c1 = 0;
        while (!rdy[0] && c1 < 100) begin @(posedge clk); #1; c1++; end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_val("pre_reset_line_low", line[0], 0);
        #2 rst[0] = 1'b1;
        #1;
        check_val("async_rst_line", line[0], 1);
        check_val("async_rst_ready", rdy[0], 1);
        check_val("async_rst_busy", busy[0], 0);
        @(posedge clk); #3;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_idle_line", line[0], 1);
        run_frame(0, 11'h5A5, 4'd0, 0, c1);

        // random frames on both instances
        for (int i = 0; i < 24; i++) begin
            run_frame(i % 2, 11'($urandom), 4'($urandom_range(0, 15)), 0, c1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
